data_sram_responder: RTL

- Responder (memory side) of the CPU data SRAM interface: accepts write-enable, address and write data from the core and returns read data with a fixed 1-cycle latency.
- Backs the normal data space with a word-addressed RAM array.
- Maps a small MMIO window (LED, switch, number and timer registers) for board I/O and self-checking tests.
- Sits between the core's data port and the board pins in the SoC top.

---
 rtl/data_sram_responder_if.sv | 25 ++
 rtl/data_sram_responder.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/data_sram_responder_if.sv
// Data SRAM bus between the CPU core (master) and the memory-side responder (slave).
//   we    : write strobe, 1 = write this cycle
//   addr  : byte address, addr[1:0] ignored by the responder
//   wdata : write data
//   rdata : read data, returned one cycle after the address cycle
interface data_sram_responder_if;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output we,
    output addr,
    output wdata,
    input  rdata
  );

  modport slave (
    input  we,
    input  addr,
    input  wdata,
    output rdata
  );
endinterface

// File: rtl/data_sram_responder.sv
// Memory-side responder for the CPU data SRAM port.
//
// Backs the normal data space with a word-addressed RAM and maps a small MMIO window
// (LED, switch, number display, free-running timer) selected by addr[31:16] == MMIO_HI.
// Read data is registered: the address presented in cycle N is answered in cycle N+1,
// with read-first behaviour when the same location is written in cycle N.
//
// Ports:
//   clk       : system clock, all state on the rising edge
//   reset     : asynchronous, active-high reset (RAM contents are not cleared)
//   data_sram : slave side of the data SRAM bus (we, addr, wdata in; rdata out)
//   switch    : raw board switches, asynchronous to clk
//   led       : LED register contents
//   num_data  : NUM register contents (7-segment display)
module data_sram_responder #(
  parameter int unsigned ADDR_W      = 12,
  parameter logic [15:0] MMIO_HI     = 16'hbfaf,
  // Legal range 2..3.
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  data_sram_responder_if.slave        data_sram,
  input  logic [7:0]                  switch,
  output logic [15:0]                 led,
  output logic [31:0]                 num_data
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  localparam logic [15:0] OffLed    = 16'hf000;
  localparam logic [15:0] OffSwitch = 16'hf010;
  localparam logic [15:0] OffNum    = 16'hf020;
  localparam logic [15:0] OffTimer  = 16'he000;

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  logic              mmio_sel;
  logic [15:0]       mmio_off;
  logic [ADDR_W-1:0] ram_idx;

  assign mmio_sel = (data_sram.addr[31:16] == MMIO_HI);
  assign mmio_off = data_sram.addr[15:0];
  // Upper bits are dropped on purpose: RAM aliases modulo DEPTH words.
  assign ram_idx  = data_sram.addr[ADDR_W+1:2];

  // Byte-lane bits are meaningless on a word-only bus.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^data_sram.addr[1:0];

  // Every write strobe is qualified by we, so an X address with we=0 cannot
  // reach any state element.
  logic ram_we;
  logic led_we;
  logic num_we;
  logic timer_we;

  assign ram_we   = data_sram.we && !mmio_sel;
  assign led_we   = data_sram.we && mmio_sel && (mmio_off == OffLed);
  assign num_we   = data_sram.we && mmio_sel && (mmio_off == OffNum);
  assign timer_we = data_sram.we && mmio_sel && (mmio_off == OffTimer);

  // --------------------------------------------------------------------------
  // RAM array (no reset, contents survive reset)
  // --------------------------------------------------------------------------
  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_idx] <= data_sram.wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Switch synchroniser
  // --------------------------------------------------------------------------
  logic [7:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= switch;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  logic [7:0] switch_synced;
  assign switch_synced = sync_q[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // MMIO registers and timer
  // --------------------------------------------------------------------------
  logic [15:0] led_q;
  logic [31:0] num_q;
  logic [31:0] timer_q;
  logic [31:0] timer_d;

  // A load wins over the increment in the same cycle.
  assign timer_d = timer_we ? data_sram.wdata : timer_q + 32'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q   <= '0;
      num_q   <= '0;
      timer_q <= '0;
    end else begin
      if (led_we) begin
        led_q <= data_sram.wdata[15:0];
      end
      if (num_we) begin
        num_q <= data_sram.wdata;
      end
      timer_q <= timer_d;
    end
  end

  assign led      = led_q;
  assign num_data = num_q;

  // --------------------------------------------------------------------------
  // Read path: mux pre-edge contents, register at the edge (read-first)
  // --------------------------------------------------------------------------
  logic [31:0] rdata_d;
  logic [31:0] rdata_q;

  always_comb begin
    rdata_d = '0;
    if (mmio_sel) begin
      case (mmio_off)
        OffLed:    rdata_d = {16'b0, led_q};
        OffSwitch: rdata_d = {24'b0, switch_synced};
        OffNum:    rdata_d = num_q;
        OffTimer:  rdata_d = timer_q;
        default:   rdata_d = '0;
      endcase
    end else begin
      rdata_d = mem[ram_idx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign data_sram.rdata = rdata_q;

endmodule
